// File: rtl/frame_bank_writer.sv
// frame_bank_writer
//   Routes non-zero valid peak samples round-robin into NUM_BANKS external frame
//   FIFOs, one FRAME_LEN-word frame per bank. A filled bank stays locked until its
//   reader has drained it. Optional frame_sync alignment, saturating overrun drop
//   counter and a sticky early-full error.
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   din, din_valid  peak sample and strobe (zero samples are never stored)
//   frame_sync      frame-boundary pulse, honoured when ALIGN_SYNC=1
//   bank_empty/full per-FIFO status flags
//   wr_data, wr_req shared FIFO write bus and one-hot write request
//   frame_done      1-cycle pulse when a bank takes its last word, done_bank = index
//   bank_locked     banks holding a complete frame awaiting readout
//   drop_cnt        samples dropped because no bank was free (saturating)
//   err_early_full  sticky: a bank reported full before its frame was complete
module frame_bank_writer #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned NUM_BANKS  = 2,
   parameter int unsigned FRAME_LEN  = 1000,
   parameter int unsigned ALIGN_SYNC = 1,
   parameter int unsigned DROP_W     = 16,
   localparam int unsigned BANK_W    = $clog2(NUM_BANKS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_W-1:0]    din,
   input  logic                 din_valid,
   input  logic                 frame_sync,
   input  logic [NUM_BANKS-1:0] bank_empty,
   input  logic [NUM_BANKS-1:0] bank_full,
   output logic [DATA_W-1:0]    wr_data,
   output logic [NUM_BANKS-1:0] wr_req,
   output logic                 frame_done,
   output logic [BANK_W-1:0]    done_bank,
   output logic [NUM_BANKS-1:0] bank_locked,
   output logic [DROP_W-1:0]    drop_cnt,
   output logic                 err_early_full
);

   localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

   typedef enum logic [1:0] {IDLE, WAIT_SYNC, WRITE, STALL} state_t;

   // State a fresh frame starts in once its bank is free
   localparam state_t OPEN_ST = (ALIGN_SYNC != 0) ? WAIT_SYNC : WRITE;

   state_t               state_q, state_d;
   logic [BANK_W-1:0]    cur_bank_q, cur_bank_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [NUM_BANKS-1:0] locked_q, locked_d;
   logic [NUM_BANKS-1:0] armed_q, armed_d;
   logic [DROP_W-1:0]    drop_q, drop_d;
   logic                 err_q, err_d;
   logic [DATA_W-1:0]    wr_data_q, wr_data_d;
   logic [NUM_BANKS-1:0] wr_req_q, wr_req_d;
   logic                 frame_done_q, frame_done_d;
   logic [BANK_W-1:0]    done_bank_q, done_bank_d;

   logic                 word_v;
   logic                 accept;
   logic                 complete;
   logic [BANK_W-1:0]    nxt_bank;

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cur_bank_q   <= '0;
         cnt_q        <= '0;
         locked_q     <= '0;
         armed_q      <= '0;
         drop_q       <= '0;
         err_q        <= 1'b0;
         wr_data_q    <= '0;
         wr_req_q     <= '0;
         frame_done_q <= 1'b0;
         done_bank_q  <= '0;
      end else begin
         state_q      <= state_d;
         cur_bank_q   <= cur_bank_d;
         cnt_q        <= cnt_d;
         locked_q     <= locked_d;
         armed_q      <= armed_d;
         drop_q       <= drop_d;
         err_q        <= err_d;
         wr_data_q    <= wr_data_d;
         wr_req_q     <= wr_req_d;
         frame_done_q <= frame_done_d;
         done_bank_q  <= done_bank_d;
      end
   end

   // Next-state, lock tracking and output decode
   always_comb begin
      state_d      = state_q;
      cur_bank_d   = cur_bank_q;
      cnt_d        = cnt_q;
      locked_d     = locked_q;
      armed_d      = armed_q;
      drop_d       = drop_q;
      err_d        = err_q;
      wr_data_d    = din;
      wr_req_d     = '0;
      frame_done_d = 1'b0;
      done_bank_d  = done_bank_q;
      accept       = 1'b0;
      complete     = 1'b0;

      word_v   = din_valid && (din != '0);
      nxt_bank = (cur_bank_q == BANK_W'(NUM_BANKS - 1)) ? '0 : cur_bank_q + 1'b1;

      // Release needs a non-empty flag first, so a lagging empty flag right
      // after the last write cannot unlock the bank prematurely.
      for (int b = 0; b < int'(NUM_BANKS); b++) begin
         if (locked_q[b]) begin
            if (armed_q[b] && bank_empty[b]) begin
               locked_d[b] = 1'b0;
               armed_d[b]  = 1'b0;
            end else if (!bank_empty[b]) begin
               armed_d[b] = 1'b1;
            end
         end
      end

      // Decisions use locked_d so a release seen this cycle lets the next word in
      case (state_q)
         IDLE: begin
            if (!locked_d[cur_bank_q]) state_d = OPEN_ST;
         end
         WAIT_SYNC: begin
            if (frame_sync) begin
               state_d = WRITE;
               accept  = 1'b1;
            end
         end
         WRITE: begin
            accept = 1'b1;
         end
         STALL: begin
            if (word_v && (drop_q != '1)) drop_d = drop_q + 1'b1;
            if (!locked_d[cur_bank_q]) state_d = OPEN_ST;
         end
         default: state_d = IDLE;
      endcase

      if (accept && word_v) begin
         if (bank_full[cur_bank_q]) begin
            // Full before the frame is complete: drop the word and close the frame
            err_d    = 1'b1;
            complete = 1'b1;
         end else begin
            wr_req_d[cur_bank_q] = 1'b1;
            if (cnt_q == CNT_W'(FRAME_LEN - 1)) complete = 1'b1;
            else                                cnt_d    = cnt_q + 1'b1;
         end
      end

      if (complete) begin
         frame_done_d         = 1'b1;
         done_bank_d          = cur_bank_q;
         locked_d[cur_bank_q] = 1'b1;
         armed_d[cur_bank_q]  = 1'b0;
         cnt_d                = '0;
         cur_bank_d           = nxt_bank;
         state_d              = locked_d[nxt_bank] ? STALL : OPEN_ST;
      end
   end

   assign wr_data        = wr_data_q;
   assign wr_req         = wr_req_q;
   assign frame_done     = frame_done_q;
   assign done_bank      = done_bank_q;
   assign bank_locked    = locked_q;
   assign drop_cnt       = drop_q;
   assign err_early_full = err_q;

endmodule

// File: tb/tb_frame_bank_writer.sv
// tb_frame_bank_writer
//   Directed bench for frame_bank_writer. Three instances cover the parameter
//   sets used: A (2 banks, 8 words, free-running, 3-bit drop counter),
//   B (2 banks, 8 words, sync-aligned) and C (3 banks, 4 words, free-running).
module tb_frame_bank_writer;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Instance A
   logic        rst_a;
   logic [15:0] din_a;
   logic        dv_a, sync_a;
   logic [1:0]  empty_a, full_a;
   logic [15:0] wd_a;
   logic [1:0]  req_a, lock_a;
   logic        fd_a, err_a;
   logic [0:0]  db_a;
   logic [2:0]  drop_a;

   // Instance B
   logic        rst_b;
   logic [15:0] din_b;
   logic        dv_b, sync_b;
   logic [1:0]  empty_b, full_b;
   logic [15:0] wd_b;
   logic [1:0]  req_b, lock_b;
   logic        fd_b, err_b;
   logic [0:0]  db_b;
   logic [15:0] drop_b;

   // Instance C
   logic        rst_c;
   logic [15:0] din_c;
   logic        dv_c, sync_c;
   logic [2:0]  empty_c, full_c;
   logic [15:0] wd_c;
   logic [2:0]  req_c, lock_c;
   logic        fd_c, err_c;
   logic [1:0]  db_c;
   logic [15:0] drop_c;

   frame_bank_writer #(.DATA_W(16), .NUM_BANKS(2), .FRAME_LEN(8), .ALIGN_SYNC(0), .DROP_W(3)) u_a (
      .clk(clk), .rst(rst_a), .din(din_a), .din_valid(dv_a), .frame_sync(sync_a),
      .bank_empty(empty_a), .bank_full(full_a), .wr_data(wd_a), .wr_req(req_a),
      .frame_done(fd_a), .done_bank(db_a), .bank_locked(lock_a), .drop_cnt(drop_a),
      .err_early_full(err_a));

   frame_bank_writer #(.DATA_W(16), .NUM_BANKS(2), .FRAME_LEN(8), .ALIGN_SYNC(1), .DROP_W(16)) u_b (
      .clk(clk), .rst(rst_b), .din(din_b), .din_valid(dv_b), .frame_sync(sync_b),
      .bank_empty(empty_b), .bank_full(full_b), .wr_data(wd_b), .wr_req(req_b),
      .frame_done(fd_b), .done_bank(db_b), .bank_locked(lock_b), .drop_cnt(drop_b),
      .err_early_full(err_b));

   frame_bank_writer #(.DATA_W(16), .NUM_BANKS(3), .FRAME_LEN(4), .ALIGN_SYNC(0), .DROP_W(16)) u_c (
      .clk(clk), .rst(rst_c), .din(din_c), .din_valid(dv_c), .frame_sync(sync_c),
      .bank_empty(empty_c), .bank_full(full_c), .wr_data(wd_c), .wr_req(req_c),
      .frame_done(fd_c), .done_bank(db_c), .bank_locked(lock_c), .drop_cnt(drop_c),
      .err_early_full(err_c));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_a = 1'b1; din_a = '0; dv_a = 1'b0; sync_a = 1'b0; empty_a = 2'b11; full_a = '0;
      rst_b = 1'b1; din_b = '0; dv_b = 1'b0; sync_b = 1'b0; empty_b = 2'b11; full_b = '0;
      rst_c = 1'b1; din_c = '0; dv_c = 1'b0; sync_c = 1'b0; empty_c = 3'b111; full_c = '0;
      #1;
      check("reset_a_req",  32'(req_a),  32'h0);
      check("reset_a_wd",   32'(wd_a),   32'h0);
      check("reset_a_lock", 32'(lock_a), 32'h0);
      check("reset_a_drop", 32'(drop_a), 32'h0);
      check("reset_a_fd",   32'(fd_a),   32'h0);
      check("reset_a_err",  32'(err_a),  32'h0);
      tick(); tick();
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      tick(); tick();

      // 1: 16 continuous words over two banks
      for (int i = 1; i <= 16; i++) begin
         din_a = 16'(i); dv_a = 1'b1;
         tick();
         check($sformatf("t1_req_w%0d", i), 32'(req_a), (i <= 8) ? 32'h1 : 32'h2);
         check($sformatf("t1_wd_w%0d", i),  32'(wd_a),  32'(i));
         check($sformatf("t1_fd_w%0d", i),  32'(fd_a),  (i == 8 || i == 16) ? 32'h1 : 32'h0);
         if (i == 8)  check("t1_db_0", 32'(db_a), 32'h0);
         if (i == 16) check("t1_db_1", 32'(db_a), 32'h1);
      end
      check("t1_locked", 32'(lock_a), 32'h3);

      // 2: both banks locked -> drops, saturation, then release of bank 0
      for (int i = 0; i < 5; i++) begin
         din_a = 16'(17 + i); dv_a = 1'b1;
         tick();
         check($sformatf("t2_noreq_%0d", i), 32'(req_a), 32'h0);
      end
      dv_a = 1'b0;
      tick();
      check("t2_drop5", 32'(drop_a), 32'h5);
      for (int i = 0; i < 4; i++) begin
         din_a = 16'(22 + i); dv_a = 1'b1;
         tick();
      end
      dv_a = 1'b0;
      tick();
      check("t2_drop_sat", 32'(drop_a), 32'h7);
      empty_a = 2'b10;
      tick();
      check("t2_still_locked", 32'(lock_a), 32'h3);
      empty_a = 2'b11;
      tick();
      check("t2_released", 32'(lock_a), 32'h2);
      din_a = 16'd30; dv_a = 1'b1;
      tick();
      check("t2_req_after_rel", 32'(req_a), 32'h1);
      check("t2_wd_after_rel",  32'(wd_a),  32'd30);
      din_a = 16'd0;
      tick();
      check("t2_zero_not_stored", 32'(req_a), 32'h0);
      din_a = 16'd31;
      tick();
      check("t2_req_next", 32'(req_a), 32'h1);
      check("t2_drop_hold", 32'(drop_a), 32'h7);
      dv_a = 1'b0;

      // 3: sync alignment, pre-sync words discarded without drop count
      for (int i = 1; i <= 3; i++) begin
         din_b = 16'(i); dv_b = 1'b1;
         tick();
         check($sformatf("t3_presync_%0d", i), 32'(req_b), 32'h0);
      end
      din_b = 16'd4; sync_b = 1'b1;
      tick();
      sync_b = 1'b0;
      check("t3_first_req", 32'(req_b), 32'h1);
      check("t3_first_wd",  32'(wd_b),  32'd4);
      check("t3_drop0",     32'(drop_b), 32'h0);

      // 4: early full on bank 0 after 5 writes
      for (int i = 5; i <= 8; i++) begin
         din_b = 16'(i);
         tick();
         check($sformatf("t4_req_w%0d", i), 32'(req_b), 32'h1);
      end
      check("t4_err_before", 32'(err_b), 32'h0);
      din_b = 16'd9; full_b = 2'b01;
      tick();
      full_b = 2'b00;
      check("t4_req_supp", 32'(req_b), 32'h0);
      check("t4_err",      32'(err_b), 32'h1);
      check("t4_fd",       32'(fd_b),  32'h1);
      check("t4_db",       32'(db_b),  32'h0);
      check("t4_lock",     32'(lock_b), 32'h1);
      din_b = 16'd10; sync_b = 1'b1;
      tick();
      sync_b = 1'b0; dv_b = 1'b0;
      check("t4_next_bank", 32'(req_b), 32'h2);
      check("t4_fd_clear",  32'(fd_b),  32'h0);
      check("t4_err_stick", 32'(err_b), 32'h1);

      // 5: three banks, drained as they go, wrap back to bank 0
      for (int i = 0; i < 12; i++) begin
         din_c = 16'(i + 1); dv_c = 1'b1;
         empty_c = 3'b111;
         if ((i % 4) == 1 && i >= 4) empty_c[(i / 4) - 1] = 1'b0;
         tick();
         check($sformatf("t5_req_w%0d", i + 1), 32'(req_c), 32'(1 << (i / 4)));
         check($sformatf("t5_fd_w%0d", i + 1),  32'(fd_c),  ((i % 4) == 3) ? 32'h1 : 32'h0);
      end
      empty_c = 3'b111;
      check("t5_db_last", 32'(db_c), 32'h2);
      check("t5_lock", 32'(lock_c), 32'h4);
      for (int i = 13; i <= 15; i++) begin
         din_c = 16'(i);
         tick();
         check($sformatf("t5_wrap_w%0d", i), 32'(req_c), 32'h1);
      end
      dv_c = 1'b0; din_c = '0;

      // 6: reset mid-frame clears outputs immediately
      rst_c = 1'b1;
      #1;
      check("t6_rst_req",  32'(req_c),  32'h0);
      check("t6_rst_wd",   32'(wd_c),   32'h0);
      check("t6_rst_lock", 32'(lock_c), 32'h0);
      check("t6_rst_fd",   32'(fd_c),   32'h0);
      check("t6_rst_db",   32'(db_c),   32'h0);
      check("t6_rst_drop", 32'(drop_c), 32'h0);
      check("t6_rst_err",  32'(err_c),  32'h0);
      tick(); tick();
      rst_c = 1'b0;
      tick(); tick();
      for (int i = 1; i <= 4; i++) begin
         din_c = 16'(100 + i); dv_c = 1'b1;
         tick();
         check($sformatf("t6_req_w%0d", i), 32'(req_c), 32'h1);
         check($sformatf("t6_fd_w%0d", i),  32'(fd_c),  (i == 4) ? 32'h1 : 32'h0);
      end
      dv_c = 1'b0;
      check("t6_db", 32'(db_c), 32'h0);
      tick();
      check("t6_lock_after", 32'(lock_c), 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
